// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single data-cache port between tagged speculative loads and an
// in-order buffer of committed stores, bounding store starvation and squashing flushed loads.
module dcache_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int TAG_W        = 4,
   parameter int SB_DEPTH     = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      ld_valid,
   input  logic [ADDR_W-1:0]         ld_addr,
   input  logic [TAG_W-1:0]          ld_tag,
   output logic                      ld_ready,
   input  logic                      st_commit_valid,
   input  logic [ADDR_W-1:0]         st_commit_addr,
   input  logic [DATA_W-1:0]         st_commit_data,
   output logic                      sb_full,
   output logic [$clog2(SB_DEPTH):0] sb_count,
   output logic                      dc_req_valid,
   output logic                      dc_req_write,
   output logic [ADDR_W-1:0]         dc_req_addr,
   output logic [DATA_W-1:0]         dc_req_data,
   input  logic                      dc_req_ready,
   input  logic                      dc_resp_valid,
   input  logic [DATA_W-1:0]         dc_resp_data,
   output logic                      ld_done_valid,
   output logic [TAG_W-1:0]          ld_done_tag,
   output logic [DATA_W-1:0]         ld_done_data,
   output logic                      busy
);
   localparam int IDX_W = $clog2(SB_DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
   logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              squash_q, squash_d;
   logic              req_write_q, req_write_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [DATA_W-1:0] req_data_q, req_data_d;
   logic [TAG_W-1:0]  req_tag_q, req_tag_d;

   logic             sb_empty, push, pop, conflict;
   logic             store_cand, load_cand, pick_store, pick_load;
   logic [IDX_W-1:0] head_idx;

   assign sb_count = wr_ptr_q - rd_ptr_q;
   assign sb_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                     (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
   assign sb_empty = (wr_ptr_q == rd_ptr_q);
   assign head_idx = rd_ptr_q[IDX_W-1:0];
   assign push     = st_commit_valid & ~sb_full;
   assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
   assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);

   // Every occupied entry is compared, including the head whose write is in flight.
   always_comb begin
      conflict = 1'b0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         if ((PTR_W'(k) < sb_count) && (sb_addr_q[head_idx + IDX_W'(k)] == ld_addr))
            conflict = 1'b1;
      end
   end

   assign store_cand = ~sb_empty;
   assign load_cand  = ld_valid & ~flush & ~conflict;
   assign pick_store = store_cand & (~load_cand | sb_full | (starve_q >= LIMIT));
   assign pick_load  = load_cand & ~pick_store;

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      starve_d      = starve_q;
      squash_d      = squash_q;
      req_write_d   = req_write_q;
      req_addr_d    = req_addr_q;
      req_data_d    = req_data_q;
      req_tag_d     = req_tag_q;
      ld_ready      = 1'b0;
      pop           = 1'b0;
      ld_done_valid = 1'b0;
      ld_done_tag   = '0;
      ld_done_data  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (pick_store) begin
               state_d     = S_REQ;
               req_write_d = 1'b1;
               req_addr_d  = sb_addr_q[head_idx];
               req_data_d  = sb_data_q[head_idx];
               starve_d    = '0;
            end else if (pick_load) begin
               state_d     = S_REQ;
               ld_ready    = 1'b1;
               req_write_d = 1'b0;
               req_addr_d  = ld_addr;
               req_data_d  = '0;
               req_tag_d   = ld_tag;
               if (store_cand)
                  starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 1'b1;
            end
         end
         S_REQ: begin
            if (flush && !req_write_q) squash_d = 1'b1;
            if (dc_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flush && !req_write_q) squash_d = 1'b1;
            if (dc_resp_valid) begin
               state_d  = S_IDLE;
               squash_d = 1'b0;
               if (req_write_q) begin
                  pop = 1'b1;
               end else if (!squash_q) begin
                  ld_done_valid = 1'b1;
                  ld_done_tag   = req_tag_q;
                  ld_done_data  = dc_resp_data;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (sb_empty) starve_d = '0;
   end

   assign busy         = (state_q != S_IDLE);
   assign dc_req_valid = (state_q == S_REQ);
   assign dc_req_write = dc_req_valid & req_write_q;
   assign dc_req_addr  = dc_req_valid ? req_addr_q : '0;
   assign dc_req_data  = dc_req_valid ? req_data_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         starve_q    <= '0;
         squash_q    <= 1'b0;
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_data_q  <= '0;
         req_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         starve_q    <= starve_d;
         squash_q    <= squash_d;
         req_write_q <= req_write_d;
         req_addr_q  <= req_addr_d;
         req_data_q  <= req_data_d;
         req_tag_q   <= req_tag_d;
      end
   end

   // NOTE: buffer storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         sb_addr_q[wr_ptr_q[IDX_W-1:0]] <= st_commit_addr;
         sb_data_q[wr_ptr_q[IDX_W-1:0]] <= st_commit_data;
      end
   end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Owns the single data-cache port. It sequences two traffic sources: speculative loads issued from the memory reservation station, and committed stores released by the ROB.
- Committed stores land in an internal in-order store buffer. They drain to the cache when the arbiter grants them.
- Loads whose address matches a buffered store are held back.
- Load results return tagged, for broadcast on the common data bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TAG_W, 4, ROB tag width
SB_DEPTH, 4, store buffer entries (power of two)
STARVE_LIMIT, 8, consecutive load grants allowed while the store buffer is non-empty

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  branch mispredict; squashes load traffic
ld_valid  in  1  load request pending
ld_addr  in  ADDR_W  load address
ld_tag  in  TAG_W  load ROB tag
ld_ready  out  1  load accepted this cycle
st_commit_valid  in  1  ROB commits a store
st_commit_addr  in  ADDR_W  store address
st_commit_data  in  DATA_W  store data
sb_full  out  1  store buffer full; ROB must not commit a store
sb_count  out  $clog2(SB_DEPTH)+1  occupied entries
dc_req_valid  out  1  cache request valid
dc_req_write  out  1  1 = store, 0 = load
dc_req_addr  out  ADDR_W  request address
dc_req_data  out  DATA_W  store data (0 for loads)
dc_req_ready  in  1  cache accepts request
dc_resp_valid  in  1  cache completes the outstanding request (loads and stores)
dc_resp_data  in  DATA_W  load data
ld_done_valid  out  1  load result valid, one-cycle pulse
ld_done_tag  out  TAG_W  tag of completed load
ld_done_data  out  DATA_W  load data
busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, store buffer empty, starve_cnt=0, squash=0. All outputs 0, except sb_count=0 and sb_full=0.
- Store buffer: circular FIFO, ptr width $clog2(SB_DEPTH)+1, wraps naturally.
  - Full: low index bits equal, MSBs differ.
  - Push on st_commit_valid. A push while sb_full is dropped; the bench flags it as an error.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - The head entry stays in the buffer until its dc_resp_valid.
- Address conflict: ld_addr equals the address of any occupied buffer entry, including the head in flight. An entry pushed in the same cycle is not checked.
- FSM states: IDLE, REQ, WAIT.
- IDLE arbitration (combinational; registered into request regs at the edge):
  - store_cand = sb_count>0.
  - load_cand = ld_valid & !flush & !conflict.
  - Pick the store if store_cand and (!load_cand or sb_full or starve_cnt>=STARVE_LIMIT). Otherwise pick the load if load_cand.
  - ld_ready=1 only in IDLE when the load is picked.
  - On any grant, go to REQ. The request regs latch the write flag, address and data (head entry, or ld_addr/ld_tag).
- REQ: dc_req_valid=1 and the request fields stay stable until dc_req_ready. On the ready cycle, go to WAIT.
- WAIT: dc_req_valid=0. On dc_resp_valid, go to IDLE.
  - Store: pop the head.
  - Load: ld_done_valid=1 for that cycle with the latched tag and dc_resp_data, unless squash=1.
  - A new grant is evaluated earliest the cycle after returning to IDLE. Minimum load latency: accept at N, req at N+1, resp at N+2 or later, done the same cycle as resp.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a load grant while sb_count>0.
  - Clears on a store grant or when sb_count==0.
- flush:
  - In IDLE: blocks the load grant that cycle.
  - In REQ/WAIT with a load: set squash. The request is still completed (valid is never withdrawn), and its response is discarded.
  - squash clears on return to IDLE.
  - Never affects the store buffer or an in-flight store.
- ld_done_* is 0 whenever ld_done_valid=0.
- busy = state!=IDLE.

Test Plan:
- Reset, then ld_valid addr=0x100 tag=3 with the buffer empty → ld_ready at cycle 0; dc_req_valid write=0 addr=0x100 at cycle 1. Cache ready at 1, resp data=0xDEADBEEF at 3 → ld_done_valid, tag=3, data=0xDEADBEEF at 3.
- Commit stores 0x200/0x11 and 0x204/0x22 → sb_count=2. Drain in order: two write requests with matching addr/data; sb_count reaches 0 after the second resp.
- Buffer holds a store to 0x300; ld addr=0x300 → ld_ready stays 0 until that store's resp. The load is then granted the next IDLE cycle.
- Fill to SB_DEPTH=4 with ld_valid continuously asserted to non-conflicting addresses → sb_full=1, the store is picked over the load. With 1 entry buffered and loads streaming, a store is granted after exactly 8 load grants.
- Load in WAIT, flush pulse, then resp → no ld_done_valid. The next load is accepted normally.
- Reset asserted mid-REQ with 3 buffered stores → next cycle dc_req_valid=0, sb_count=0, busy=0.
